irq_trap_controller: RTL and testbench
======================================

// Module: irq_trap_controller
// PURPOSE
//  Machine-mode interrupt controller beside the CSR unit. Owns mstatus.MIE/MPIE, mie and mip;
//  synchronises interrupt sources, masks and prioritises them, and raises a held trap request
//  to the core. Core acks at an instruction boundary; CSR unit then loads mepc/mcause.
// PARAMETERS
//  XLEN         64      data/CSR width
//  SYNC_STAGES  2       flop stages on irq_ext (>=2)
//  MSTATUS_ADDR 12'h300 mstatus CSR address
//  MIE_ADDR     12'h304 mie CSR address
//  MIP_ADDR     12'h344 mip CSR address
// PORTS
//  clk          in   1     clock
//  rst          in   1     asynchronous, active-low reset
//  irq_ext      in   1     external interrupt, level, asynchronous
//  irq_timer    in   1     timer interrupt, level, clk-synchronous
//  irq_soft     in   1     software interrupt, level, clk-synchronous
//  csr_we       in   1     CSR write strobe (final value, RMW already resolved)
//  csr_addr     in   12    CSR address for read and write
//  csr_wdata    in   XLEN  CSR write value
//  csr_rdata    out  XLEN  read data for csr_addr (combinational)
//  csr_hit      out  1     csr_addr is one of the three owned CSRs
//  trap_req     out  1     interrupt trap request to core
//  trap_cause   out  XLEN  mcause value for trap_req
//  trap_ack     in   1     core takes the trap this cycle
//  mret_valid   in   1     MRET retiring this cycle
//  irq_pending  out  1     any (mip & mie) != 0, ignores MIE (WFI wake)
// BEHAVIOUR
//  Reset (async, rst=0): all flops 0; state IDLE; trap_req=0, trap_cause=0, irq_pending=0.
//  Implemented bits only: mstatus[3]=MIE, mstatus[7]=MPIE; mie/mip bits 3 MSI, 7 MTI, 11 MEI.
//   All other bits read 0, writes ignored. mip is read-only; writes to MIP_ADDR dropped.
//  Sampling: mip.MTIP/MSIP <= irq_timer/irq_soft every edge (1 edge latency).
//   mip.MEIP <= last stage of SYNC_STAGES chain on irq_ext (SYNC_STAGES edges latency).
//  enabled = mip & mie; irq_pending = |enabled (combinational from flops).
//  Priority: MEI > MSI > MTI. cause = {1'b1, code}, code 11/3/7, zero-extended to XLEN.
//  FSM:
//   IDLE:     if mstatus.MIE && |enabled -> REQ; latch trap_cause of highest enabled.
//   REQ:      trap_req=1; trap_cause held stable until ack even if source drops/masked
//             (spurious trap; software re-reads mip). On trap_ack -> COOLDOWN and same edge
//             MPIE<=MIE, MIE<=0.
//   COOLDOWN: trap_req=0, one cycle, no new request -> IDLE.
//  trap_req is a registered output: rises first cycle in REQ, falls the cycle after ack.
//  trap_ack outside REQ: ignored.
//  mret_valid: MIE<=MPIE, MPIE<=1. Ignored if trap_ack is accepted in the same cycle.
//  Same-cycle priority on mstatus: accepted trap_ack > mret_valid > csr_we.
//  mie writes apply at the edge; IDLE decision uses registered values (1-cycle mask delay).
//  csr_we to mstatus clearing MIE while in REQ does not withdraw the request.
//  Reset asserted mid-REQ: trap_req drops immediately (async), no ack required.
// TESTING
//  1 Reset, mie=0x80, mstatus=0x8, irq_timer=1 at edge 0 -> mip=0x80 after edge 0, trap_req=1
//    after edge 1, trap_cause=0x8000_0000_0000_0007.
//  2 mie=0x888, all three irqs high -> trap_cause=...000B; ack -> mstatus=0x80, trap_req=0 next
//    cycle; then mret_valid -> mstatus=0x88.
//  3 irq_ext pulse -> mip.MEIP set exactly SYNC_STAGES edges later; irq_pending=1 with
//    mstatus.MIE=0 and trap_req stays 0.
//  4 In REQ, drop irq_timer and write mie=0 -> trap_req and trap_cause held until trap_ack.
//  5 trap_ack and mret_valid and csr_we(mstatus,0x88) same cycle -> mstatus=0x80 after edge.
//  6 rst low during REQ -> trap_req=0 without clk edge; csr_rdata for mip/mie/mstatus = 0.

Source files
------------

// File: rtl/irq_trap_controller.sv
// Machine-mode interrupt controller: owns mstatus.MIE/MPIE, mie and mip, synchronises and
// prioritises interrupt sources, and holds a trap request until the core acknowledges it.
module irq_trap_controller #(
  parameter int          XLEN         = 64,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [11:0] MSTATUS_ADDR = 12'h300,
  parameter logic [11:0] MIE_ADDR     = 12'h304,
  parameter logic [11:0] MIP_ADDR     = 12'h344
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_soft,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_hit,
  output logic            trap_req,
  output logic [XLEN-1:0] trap_cause,
  input  logic            trap_ack,
  input  logic            mret_valid,
  output logic            irq_pending
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    COOLDOWN
  } state_t;

  // Compact interrupt vectors: index 0 = MSI (bit 3), 1 = MTI (bit 7), 2 = MEI (bit 11).
  localparam int MSI = 0;
  localparam int MTI = 1;
  localparam int MEI = 2;

  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;
  localparam logic [3:0] CODE_MEI = 4'd11;

  state_t                 state;
  logic                   mstatus_mie;
  logic                   mstatus_mpie;
  logic [2:0]             mie_q;
  logic                   msip_q;
  logic                   mtip_q;
  logic [SYNC_STAGES-1:0] ext_sync;
  logic [2:0]             mip_bits;
  logic [2:0]             enabled;
  logic [3:0]             next_code;
  logic                   ack_accept;
  logic                   unused_wdata;

  function automatic logic [XLEN-1:0] expand_irq(input logic [2:0] bits);
    logic [XLEN-1:0] v;
    v     = '0;
    v[3]  = bits[MSI];
    v[7]  = bits[MTI];
    v[11] = bits[MEI];
    return v;
  endfunction

  // The last synchroniser stage is the MEIP flop itself, giving SYNC_STAGES edges of latency.
  assign mip_bits    = {ext_sync[SYNC_STAGES-1], mtip_q, msip_q};
  assign enabled     = mip_bits & mie_q;
  assign irq_pending = |enabled;
  assign ack_accept  = (state == REQ) && trap_ack;

  assign unused_wdata = &{1'b0, csr_wdata};

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    next_code = CODE_MTI;
    if (enabled[MEI])      next_code = CODE_MEI;
    else if (enabled[MSI]) next_code = CODE_MSI;
  end

  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b0;
    if (csr_addr == MSTATUS_ADDR) begin
      csr_hit      = 1'b1;
      csr_rdata[3] = mstatus_mie;
      csr_rdata[7] = mstatus_mpie;
    end else if (csr_addr == MIE_ADDR) begin
      csr_hit   = 1'b1;
      csr_rdata = expand_irq(mie_q);
    end else if (csr_addr == MIP_ADDR) begin
      csr_hit   = 1'b1;
      csr_rdata = expand_irq(mip_bits);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_sync <= '0;
      msip_q   <= 1'b0;
      mtip_q   <= 1'b0;
    end else begin
      ext_sync <= {ext_sync[SYNC_STAGES-2:0], irq_ext};
      msip_q   <= irq_soft;
      mtip_q   <= irq_timer;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mie_q <= '0;
    end else if (csr_we && (csr_addr == MIE_ADDR)) begin
      mie_q <= {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
    end
  end

  // Trap entry beats MRET, which beats a software write of mstatus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (ack_accept) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_valid) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_we && (csr_addr == MSTATUS_ADDR)) begin
      mstatus_mie  <= csr_wdata[3];
      mstatus_mpie <= csr_wdata[7];
    end
  end

  // Once in REQ the cause is frozen; a source that drops yields a spurious trap that software resolves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      trap_req   <= 1'b0;
      trap_cause <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mstatus_mie && irq_pending) begin
            state      <= REQ;
            trap_req   <= 1'b1;
            trap_cause <= {1'b1, {(XLEN-5){1'b0}}, next_code};
          end
        end
        REQ: begin
          if (trap_ack) begin
            state    <= COOLDOWN;
            trap_req <= 1'b0;
          end
        end
        COOLDOWN: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          trap_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_trap_controller.sv
// Directed bench for irq_trap_controller: stimulus pushes expected trap causes into a queue,
// a negedge monitor pops them when trap_req rises and checks the cause stays stable while held.
`timescale 1ns/1ps
module tb_irq_trap_controller;

  localparam int          XLEN    = 64;
  localparam logic [11:0] A_MSTAT = 12'h300;
  localparam logic [11:0] A_MIE   = 12'h304;
  localparam logic [11:0] A_MIP   = 12'h344;

  localparam logic [63:0] C_MSI = 64'h8000_0000_0000_0003;
  localparam logic [63:0] C_MTI = 64'h8000_0000_0000_0007;
  localparam logic [63:0] C_MEI = 64'h8000_0000_0000_000B;

  logic            clk = 1'b0;
  logic            rst;
  logic            irq_ext, irq_timer, irq_soft;
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_hit;
  logic            trap_req;
  logic [XLEN-1:0] trap_cause;
  logic            trap_ack;
  logic            mret_valid;
  logic            irq_pending;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_cause_q[$];
  logic [63:0] held_cause;
  bit          prev_req;

  irq_trap_controller dut (
    .clk        (clk),
    .rst        (rst),
    .irq_ext    (irq_ext),
    .irq_timer  (irq_timer),
    .irq_soft   (irq_soft),
    .csr_we     (csr_we),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .csr_hit    (csr_hit),
    .trap_req   (trap_req),
    .trap_cause (trap_cause),
    .trap_ack   (trap_ack),
    .mret_valid (mret_valid),
    .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [63:0] data);
    csr_we    = 1'b1;
    csr_addr  = addr;
    csr_wdata = data;
    step();
    csr_we    = 1'b0;
    csr_wdata = '0;
  endtask

  task automatic check_csr(input string name, input logic [11:0] addr, input logic [63:0] exp);
    csr_addr = addr;
    #0.1;
    check(name, csr_rdata, exp);
  endtask

  // Scoreboard monitor: a rising trap_req consumes one expected cause; a held request must not change it.
  always @(negedge clk) begin
    if (!rst) begin
      prev_req = 1'b0;
    end else begin
      if (trap_req && !prev_req) begin
        if (exp_cause_q.size() == 0) begin
          check("sb_unexpected_trap", trap_cause, 64'h0);
          check("sb_unexpected_req", {63'b0, trap_req}, 64'h0);
          held_cause = trap_cause;
        end else begin
          held_cause = exp_cause_q.pop_front();
          check("sb_cause", trap_cause, held_cause);
        end
      end else if (trap_req) begin
        check("sb_cause_held", trap_cause, held_cause);
      end
      prev_req = trap_req;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b0;
    irq_ext    = 1'b0;
    irq_timer  = 1'b0;
    irq_soft   = 1'b0;
    csr_we     = 1'b0;
    csr_addr   = '0;
    csr_wdata  = '0;
    trap_ack   = 1'b0;
    mret_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_trap_req", {63'b0, trap_req}, 64'h0);
    check("rst_trap_cause", trap_cause, 64'h0);
    check("rst_pending", {63'b0, irq_pending}, 64'h0);
    check_csr("rst_mstatus", A_MSTAT, 64'h0);
    rst = 1'b1;
    step();

    csr_addr = A_MIE;
    #0.1;
    check("hit_mie", {63'b0, csr_hit}, 64'h1);
    csr_addr = 12'h305;
    #0.1;
    check("hit_other", {63'b0, csr_hit}, 64'h0);
    check("rdata_other", csr_rdata, 64'h0);

    // Timer interrupt: one edge to mip, one more to trap_req.
    csr_write(A_MIE, 64'h80);
    csr_write(A_MSTAT, 64'h8);
    check_csr("t1_mstatus", A_MSTAT, 64'h8);
    irq_timer = 1'b1;
    exp_cause_q.push_back(C_MTI);
    step();
    check_csr("t1_mip_edge0", A_MIP, 64'h80);
    check("t1_req_edge0", {63'b0, trap_req}, 64'h0);
    step();
    check("t1_req_edge1", {63'b0, trap_req}, 64'h1);
    check("t1_cause", trap_cause, C_MTI);
    trap_ack  = 1'b1;
    irq_timer = 1'b0;
    step();
    trap_ack = 1'b0;
    check("t1_req_after_ack", {63'b0, trap_req}, 64'h0);
    check_csr("t1_mstatus_ack", A_MSTAT, 64'h80);
    mret_valid = 1'b1;
    step();
    mret_valid = 1'b0;
    check_csr("t1_mstatus_mret", A_MSTAT, 64'h88);

    // Unimplemented bits and read-only mip.
    csr_write(A_MIE, '1);
    check_csr("mie_mask", A_MIE, 64'h888);
    csr_write(A_MIP, '1);
    check_csr("mip_ro", A_MIP, 64'h0);

    // All three sources: external wins.
    csr_write(A_MSTAT, 64'h0);
    irq_ext   = 1'b1;
    irq_timer = 1'b1;
    irq_soft  = 1'b1;
    repeat (3) step();
    check_csr("t2_mip_all", A_MIP, 64'h888);
    check("t2_pending", {63'b0, irq_pending}, 64'h1);
    check("t2_req_masked", {63'b0, trap_req}, 64'h0);
    exp_cause_q.push_back(C_MEI);
    csr_write(A_MSTAT, 64'h8);
    step();
    check("t2_req", {63'b0, trap_req}, 64'h1);
    check("t2_cause", trap_cause, C_MEI);
    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    check("t2_req_after_ack", {63'b0, trap_req}, 64'h0);
    check_csr("t2_mstatus_ack", A_MSTAT, 64'h80);
    irq_ext   = 1'b0;
    irq_timer = 1'b0;
    irq_soft  = 1'b0;
    repeat (3) step();
    check("t2_req_idle", {63'b0, trap_req}, 64'h0);
    mret_valid = 1'b1;
    step();
    mret_valid = 1'b0;
    check_csr("t2_mstatus_mret", A_MSTAT, 64'h88);

    // External pulse through the synchroniser with MIE clear.
    csr_write(A_MSTAT, 64'h0);
    irq_ext = 1'b1;
    step();
    irq_ext = 1'b0;
    check_csr("t3_mip_edge1", A_MIP, 64'h0);
    step();
    check_csr("t3_mip_edge2", A_MIP, 64'h800);
    check("t3_pending", {63'b0, irq_pending}, 64'h1);
    check("t3_no_req", {63'b0, trap_req}, 64'h0);
    step();
    check_csr("t3_mip_edge3", A_MIP, 64'h0);
    check("t3_pending_clr", {63'b0, irq_pending}, 64'h0);

    // Request held after the source drops and is masked.
    irq_timer = 1'b1;
    step();
    exp_cause_q.push_back(C_MTI);
    csr_write(A_MSTAT, 64'h8);
    step();
    check("t4_req", {63'b0, trap_req}, 64'h1);
    irq_timer = 1'b0;
    csr_write(A_MIE, 64'h0);
    csr_write(A_MSTAT, 64'h0);
    step();
    check("t4_req_held", {63'b0, trap_req}, 64'h1);
    check("t4_cause_held", trap_cause, C_MTI);
    check("t4_pending", {63'b0, irq_pending}, 64'h0);
    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    check("t4_req_after_ack", {63'b0, trap_req}, 64'h0);
    check_csr("t4_mstatus", A_MSTAT, 64'h0);

    // Ack, MRET and mstatus write in one cycle: the ack wins.
    csr_write(A_MIE, 64'h8);
    irq_soft = 1'b1;
    step();
    exp_cause_q.push_back(C_MSI);
    csr_write(A_MSTAT, 64'h88);
    step();
    check("t5_req", {63'b0, trap_req}, 64'h1);
    check("t5_cause", trap_cause, C_MSI);
    trap_ack   = 1'b1;
    mret_valid = 1'b1;
    csr_we     = 1'b1;
    csr_addr   = A_MSTAT;
    csr_wdata  = 64'h88;
    step();
    trap_ack   = 1'b0;
    mret_valid = 1'b0;
    csr_we     = 1'b0;
    csr_wdata  = '0;
    irq_soft   = 1'b0;
    check_csr("t5_mstatus", A_MSTAT, 64'h80);
    check("t5_req_after_ack", {63'b0, trap_req}, 64'h0);

    // Ack outside REQ leaves mstatus untouched.
    repeat (2) step();
    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    check_csr("ack_idle_mstatus", A_MSTAT, 64'h80);

    // Asynchronous reset while a request is outstanding.
    csr_write(A_MIE, 64'h80);
    csr_write(A_MSTAT, 64'h8);
    irq_timer = 1'b1;
    exp_cause_q.push_back(C_MTI);
    repeat (2) step();
    check("t6_req", {63'b0, trap_req}, 64'h1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #0.5;
    check("t6_req_async", {63'b0, trap_req}, 64'h0);
    check("t6_cause_async", trap_cause, 64'h0);
    check_csr("t6_mip", A_MIP, 64'h0);
    check_csr("t6_mie", A_MIE, 64'h0);
    check_csr("t6_mstatus", A_MSTAT, 64'h0);
    irq_timer = 1'b0;
    step();
    rst = 1'b1;
    step();

    check("sb_drain", 64'(exp_cause_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
